// File: rtl/popcount11_unary_gen.sv
// Count-to-unary generator: turns a count 0..N_BITS into an N_BITS-wide thermometer
// word and streams the same pattern one bit per valid/ready handshake.
module popcount11_unary_gen #(
    parameter int N_BITS = 11,
    parameter int CW     = $clog2(N_BITS + 1),
    parameter int ORDER  = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [CW-1:0]     in_count,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic [N_BITS-1:0] out_word,
    output logic              sat,
    output logic [0:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising clk edge where valid and ready are
    // both high; valid never waits on ready, and the payload holds while valid & !ready.

    localparam logic [CW-1:0] MAX_CNT  = CW'(N_BITS);
    localparam logic [CW-1:0] LAST_IDX = CW'(N_BITS - 1);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       idx;
    logic [CW-1:0]       count_sat;
    logic [CW-1:0]       cnt_in_sat;
    logic [N_BITS-1:0]   therm;
    logic                accept;
    logic                advance;

    always_comb begin
        cnt_in_sat = (in_count > MAX_CNT) ? MAX_CNT : in_count;
    end

    always_comb begin
        therm = '0;
        for (int i = 0; i < N_BITS; i++) begin
            therm[i] = (CW'(i) < cnt_in_sat);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Outputs decode only registered state, so no input reaches an output combinationally.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_bit   = 1'b0;
        out_last  = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                out_valid = 1'b1;
                out_last  = (idx == LAST_IDX);
                if (ORDER == 0) begin
                    out_bit = (idx < count_sat);
                end else begin
                    out_bit = (idx >= (MAX_CNT - count_sat));
                end
                if (out_ready && out_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid & in_ready;
    assign advance   = out_valid & out_ready;
    assign dbg_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx       <= '0;
            count_sat <= '0;
            out_word  <= '0;
            sat       <= 1'b0;
        end else if (accept) begin
            idx       <= '0;
            count_sat <= cnt_in_sat;
            out_word  <= therm;
            sat       <= (in_count > MAX_CNT);
        end else if (advance) begin
            // Wrap to zero after the last bit so idx is clean while idle.
            idx <= out_last ? '0 : idx + 1'b1;
        end
    end

endmodule
